// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Parametrised, pipelined add/subtract unit. The WIDTH-bit carry chain is
//   split into STAGES equal chunks of CHUNK bits; stage k resolves chunk k
//   using the carry registered by stage k-1. Operands that are not yet
//   consumed travel up the pipe in skew registers. Resolved result chunks
//   travel alongside in deskew registers. Every stage shifts together under a
//   single valid/ready advance condition.
//
// Parameters
//   WIDTH   operand/result width in bits
//   STAGES  number of pipeline stages (= latency); must divide WIDTH
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle
//   A, B       operands
//   cin        carry-in (add) / borrow-in (sub)
//   op_sub     0: A+B+cin   1: A-B-cin
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of MSB (sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned CW    = CHUNK + 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH");
  end

  // Whole pipe moves in lock-step: a slot may be overwritten whenever the
  // output slot is empty or is being consumed this cycle.
  logic advance;
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Subtraction as A + ~B + ~cin.
  logic [WIDTH-1:0] bx;
  logic             c0;
  assign bx = op_sub ? ~B : B;
  assign c0 = op_sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // LO: result bits already resolved before this stage.
    // UP: operand bits still unresolved on entry (including this chunk).
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned UP = WIDTH - LO;

    logic                v_in;
    logic                c_in;
    logic [UP-1:0]       a_in;
    logic [UP-1:0]       bx_in;
    logic [CHUNK:0]      chunk_sum;
    logic [LO+CHUNK-1:0] res_d;
    logic [LO+CHUNK-1:0] res_q;
    logic                v_q;
    logic                c_q;

    if (k == 0) begin : g_head
      assign v_in  = in_valid;
      assign c_in  = c0;
      assign a_in  = A;
      assign bx_in = bx;
      assign res_d = chunk_sum[CHUNK-1:0];
    end else begin : g_body
      assign v_in  = g_stg[k-1].v_q;
      assign c_in  = g_stg[k-1].c_q;
      assign a_in  = g_stg[k-1].g_skew.a_q;
      assign bx_in = g_stg[k-1].g_skew.bx_q;
      assign res_d = {chunk_sum[CHUNK-1:0], g_stg[k-1].res_q};
    end

    assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bx_in[CHUNK-1:0]} + CW'(c_in);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= chunk_sum[CHUNK];
        res_q <= res_d;
      end
    end

    if (UP > CHUNK) begin : g_skew
      // Upper operand chunks not yet consumed ride along with the beat.
      logic [UP-CHUNK-1:0] a_q;
      logic [UP-CHUNK-1:0] bx_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (advance) begin
          a_q  <= a_in[UP-1:CHUNK];
          bx_q <= bx_in[UP-1:CHUNK];
        end
      end
    end else begin : g_tail
      // Final stage: the top chunk carries the operand sign bits, so the
      // overflow and zero flags are formed here and registered with the sum.
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;

      assign ovf_d  = (a_in[CHUNK-1] == bx_in[CHUNK-1]) &&
                      (chunk_sum[CHUNK-1] != a_in[CHUNK-1]);
      assign zero_d = ~|res_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].res_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;
  assign zero      = g_stg[STAGES-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 32-bit/4-stage instance and an 8-bit/1-stage
// instance, driven through a common step task with per-instance scoreboards.
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
    bit          zero;
    int          acc_step;
    bit          lat_on;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          c;
    bit          s;
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
    bit          zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic        iv0, ir0, ov0, or0, cin0, sub0, co0, of0, z0;
  logic [31:0] a0, b0, s0;
  logic        iv1, ir1, ov1, or1, cin1, sub1, co1, of1, z1;
  logic [7:0]  a1, b1, s1;

  int   total = 0;
  int   bad   = 0;
  int   stepn = 0;
  int   nout0 = 0;
  int   nout1 = 0;
  bit   lat_on = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .cin(cin0), .op_sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(s0),
    .cout(co0), .ovf(of0), .zero(z0)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .cin(cin1), .op_sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .ovf(of1), .zero(z1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (step %0d)", nm, act, want, stepn);
    end
  endtask

  // Reference: plain wide integer arithmetic, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input bit c, input bit s);
    exp_t   e;
    longint m, half, ua, ub, sa, sb, cc, r, tr;
    e    = '{default: 0};
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'h0, a}) & m;
    ub   = longint'({32'h0, b}) & m;
    cc   = longint'(c);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (s) begin
      r      = ua - ub - cc;
      tr     = sa - sb - cc;
      e.cout = (r >= 0);
    end else begin
      r      = ua + ub + cc;
      tr     = sa + sb + cc;
      e.cout = (r > m);
    end
    e.sum  = 32'(r & m);
    e.ovf  = (tr >= half) || (tr < -half);
    e.zero = ((r & m) == 0);
    return e;
  endfunction

  // One cycle: drive inputs just after negedge, sample at +1, score, advance.
  task automatic step(input int d, input bit v, input logic [31:0] a, input logic [31:0] b,
                      input bit c, input bit s, input bit ordy, input exp_t e,
                      output bit acc, output bit rdy);
    exp_t x;
    bit   taken;
    bit   empty;
    if (d == 0) begin
      iv0 = v; a0 = a; b0 = b; cin0 = c; sub0 = s; or0 = ordy;
    end else begin
      iv1 = v; a1 = a[7:0]; b1 = b[7:0]; cin1 = c; sub1 = s; or1 = ordy;
    end
    #1;
    taken = (d == 0) ? (ov0 && or0) : (ov1 && or1);
    rdy   = (d == 0) ? ir0 : ir1;
    acc   = v && rdy;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (taken) begin
      if (empty) begin
        check((d == 0) ? "spurious32" : "spurious8", 64'(taken), 64'(0));
      end else begin
        if (d == 0) begin
          x = q0.pop_front();
          nout0++;
          check("out32", 64'({co0, of0, z0, s0}), 64'({x.cout, x.ovf, x.zero, x.sum}));
        end else begin
          x = q1.pop_front();
          nout1++;
          check("out8", 64'({co1, of1, z1, 24'h0, s1}), 64'({x.cout, x.ovf, x.zero, x.sum}));
        end
        if (x.lat_on) check("latency", 64'(stepn - x.acc_step), 64'((d == 0) ? 4 : 1));
      end
    end
    if (acc) begin
      e.acc_step = stepn;
      e.lat_on   = lat_on;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    stepn++;
  endtask

  task automatic drain(input int d, input string nm);
    exp_t e0;
    bit   acc, rdy;
    e0 = '{default: 0};
    for (int i = 0; i < 60; i++) begin
      if (((d == 0) ? q0.size() : q1.size()) == 0) break;
      step(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e0, acc, rdy);
    end
    check(nm, 64'((d == 0) ? q0.size() : q1.size()), 64'(0));
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'(1) << (w - 1);
      3:       return (32'(1) << (w - 1)) - 1;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int d, input int n, input string nm);
    int          w, sent, base;
    bit          acc, rdy, v, ordy, c, s;
    logic [31:0] a, b;
    exp_t        e;
    w    = (d == 0) ? 32 : 8;
    sent = 0;
    base = (d == 0) ? nout0 : nout1;
    a = pick(w); b = pick(w); c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
    for (int t = 0; t < 4 * n + 100 && sent < n; t++) begin
      v    = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 7);
      e    = model(w, a, b, c, s);
      step(d, v, a, b, c, s, ordy, e, acc, rdy);
      if (acc) begin
        sent++;
        a = pick(w); b = pick(w); c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      end
    end
    check({nm, "_sent"}, 64'(sent), 64'(n));
    drain(d, {nm, "_drain"});
    check({nm, "_count"}, 64'(((d == 0) ? nout0 : nout1) - base), 64'(n));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    exp_t e;
    bit   acc, rdy, ordy;
    int   base, i;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    iv0 = 0; a0 = '0; b0 = '0; cin0 = 0; sub0 = 0; or0 = 1;
    iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; or1 = 1;
    #2;
    check("reset32", 64'({ov0, co0, of0, z0, s0}), 64'(0));
    check("reset8", 64'({ov1, co1, of1, z1, s1}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back-to-back, no backpressure: latency also checked.
    e = '{default: 0};
    step(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, acc, rdy);
    check("ready_after_reset", 64'(rdy), 64'(1));
    lat_on = 1'b1;
    base = nout0;
    foreach (tbl[k]) begin
      e      = '{default: 0};
      e.sum  = tbl[k].sum;
      e.cout = tbl[k].cout;
      e.ovf  = tbl[k].ovf;
      e.zero = tbl[k].zero;
      step(0, 1'b1, tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].s, 1'b1, e, acc, rdy);
      check("vec_accept", 64'(acc), 64'(1));
    end
    drain(0, "vec_drain");
    check("vec_count", 64'(nout0 - base), 64'(10));

    // Eight beats with downstream stalled on cycles 6..8.
    lat_on = 1'b0;
    base = nout0;
    i = 1;
    for (int t = 1; t <= 60 && (i <= 8 || q0.size() > 0); t++) begin
      ordy = !(t >= 6 && t <= 8);
      e = model(32, 32'(i), 32'(i), 1'b0, 1'b0);
      step(0, (i <= 8), 32'(i), 32'(i), 1'b0, 1'b0, ordy, e, acc, rdy);
      if (t >= 6 && t <= 8) check("stall_in_ready", 64'(rdy), 64'(0));
      if (acc) i++;
    end
    check("stream_count", 64'(nout0 - base), 64'(8));

    // Reset with three beats in flight and the first one stalled at the output.
    for (int k = 1; k <= 3; k++) begin
      e = model(32, 32'(k * 100), 32'(k), 1'b0, 1'b0);
      step(0, 1'b1, 32'(k * 100), 32'(k), 1'b0, 1'b0, 1'b0, e, acc, rdy);
    end
    e = '{default: 0};
    step(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e, acc, rdy);
    step(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e, acc, rdy);
    check("pre_reset_valid", 64'(ov0), 64'(1));
    rst = 1'b1;
    #1;
    check("async_reset_out", 64'({ov0, co0, of0, z0, s0}), 64'(0));
    q0.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = nout0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, acc, rdy);
      if (k == 0) check("ready_after_midreset", 64'(rdy), 64'(1));
    end
    lat_on = 1'b1;
    e = model(32, 32'd3, 32'd4, 1'b0, 1'b0);
    step(0, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, e, acc, rdy);
    drain(0, "post_reset_drain");
    check("post_reset_count", 64'(nout0 - base), 64'(1));

    // 8-bit single-stage instance: directed then random.
    base = nout1;
    e = '{default: 0};
    e.sum = 32'h01; e.cout = 1'b1; e.ovf = 1'b0; e.zero = 1'b0;
    step(1, 1'b1, 32'hFF, 32'h01, 1'b1, 1'b0, 1'b1, e, acc, rdy);
    drain(1, "w8_drain");
    check("w8_count", 64'(nout1 - base), 64'(1));
    lat_on = 1'b0;

    rand_run(1, 10000, "rand8");
    rand_run(0, 2000, "rand32");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
